// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide sequencer: op codes, FSM states, default latencies.
package mdu_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } md_state_e;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  function automatic logic md_is_start(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational mult/div datapath on latched operands; returns {hi,lo} and a divide-by-zero flag.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [63:0] o_res,
  output logic        o_div_zero
);

  logic [31:0] w_ma, w_mb, w_q, w_r;

  // Signed divide runs on magnitudes; 0x80000000 is its own magnitude when read unsigned.
  assign w_ma = i_a[31] ? (32'd0 - i_a) : i_a;
  assign w_mb = i_b[31] ? (32'd0 - i_b) : i_b;

  always_comb begin
    o_res      = '0;
    o_div_zero = 1'b0;
    w_q        = '0;
    w_r        = '0;
    case (i_op)
      MD_MULT:  o_res = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
      MD_MULTU: o_res = {32'd0, i_a} * {32'd0, i_b};
      MD_DIV: begin
        if (i_b == 32'd0) begin
          o_div_zero = 1'b1;
        end else begin
          w_q = w_ma / w_mb;
          w_r = w_ma % w_mb;
          if (i_a[31] ^ i_b[31]) w_q = 32'd0 - w_q;
          if (i_a[31]) w_r = 32'd0 - w_r;
          o_res = {w_r, w_q};
        end
      end
      MD_DIVU: begin
        if (i_b == 32'd0) o_div_zero = 1'b1;
        else              o_res = {i_a % i_b, i_a / i_b};
      end
      default: o_res = '0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer with HI/LO registers.
// Optional MDU_CANCEL_EN adds cancelE to flush an in-flight op or block IDLE-side writes.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  mdOpE,
  input  logic [31:0] in1E,
  input  logic [31:0] in2E,
`ifdef MDU_CANCEL_EN
  input  logic        cancelE,
`endif
  output logic        startE,
  output logic        busyE,
  output logic [31:0] mdOutE,
  output logic [31:0] hiE,
  output logic [31:0] loE
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  md_state_e   r_state, w_state_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [31:0] r_hi, r_lo, r_a, r_b, w_hi_n, w_lo_n, w_a_n, w_b_n;
  logic [3:0]  r_op, w_op_n;
  logic [63:0] w_res;
  logic        w_div_zero, w_cancel;

`ifdef MDU_CANCEL_EN
  assign w_cancel = cancelE;
`else
  assign w_cancel = 1'b0;
`endif

  mdu_arith u_arith (
    .i_op       (r_op),
    .i_a        (r_a),
    .i_b        (r_b),
    .o_res      (w_res),
    .o_div_zero (w_div_zero)
  );

  assign startE = md_is_start(mdOpE);
  assign busyE  = (r_state == S_RUN);
  assign hiE    = r_hi;
  assign loE    = r_lo;
  assign mdOutE = (mdOpE == MD_MFHI) ? r_hi : (mdOpE == MD_MFLO) ? r_lo : 32'd0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_hi    <= w_hi_n;
      r_lo    <= w_lo_n;
      r_op    <= w_op_n;
      r_a     <= w_a_n;
      r_b     <= w_b_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_hi_n    = r_hi;
    w_lo_n    = r_lo;
    w_op_n    = r_op;
    w_a_n     = r_a;
    w_b_n     = r_b;
    case (r_state)
      S_IDLE: begin
        if (!w_cancel) begin
          if (startE) begin
            w_state_n = S_RUN;
            w_op_n    = mdOpE;
            w_a_n     = in1E;
            w_b_n     = in2E;
            w_cnt_n   = md_is_div(mdOpE) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          end else if (mdOpE == MD_MTHI) begin
            w_hi_n = in1E;
          end else if (mdOpE == MD_MTLO) begin
            w_lo_n = in1E;
          end
        end
      end
      S_RUN: begin
        if (w_cancel) begin
          w_state_n = S_IDLE;
          w_cnt_n   = '0;
        end else if (r_cnt == CW'(1)) begin
          // Divide by zero still burns the full latency but leaves HI/LO alone.
          w_state_n = S_IDLE;
          w_cnt_n   = '0;
          if (!w_div_zero) begin
            w_hi_n = w_res[63:32];
            w_lo_n = w_res[31:0];
          end
        end else begin
          w_cnt_n = r_cnt - CW'(1);
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboarded bench for mdu_ctrl: directed cases plus randomized ops against a plain-arithmetic model.
module tb_mdu_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk, reset_n;
  logic [3:0]  mdOpE;
  logic [31:0] in1E, in2E;
  logic        cancelE;
  logic        startE, busyE;
  logic [31:0] mdOutE, hiE, loE;

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .mdOpE   (mdOpE),
    .in1E    (in1E),
    .in2E    (in2E),
`ifdef MDU_CANCEL_EN
    .cancelE (cancelE),
`endif
    .startE  (startE),
    .busyE   (busyE),
    .mdOutE  (mdOutE),
    .hiE     (hiE),
    .loE     (loE)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] m_hi = 0, m_lo = 0, pend_hi = 0, pend_lo = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: HI/LO after an op, plus divide-by-zero flag, from plain language arithmetic.
  function automatic logic [64:0] ref_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sp;
    logic [63:0] ua, ub, up;
    int          sa, sbv, q, r;
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      4'd1: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        return {1'b0, sp[63:0]};
      end
      4'd2: begin
        up = ua * ub;
        return {1'b0, up};
      end
      4'd3: begin
        if (b == 0) return {1'b1, 64'd0};
        sa = a; sbv = b;
        if (sa == 32'h80000000 && sbv == -1) begin q = sa; r = 0; end
        else begin q = sa / sbv; r = sa % sbv; end
        return {1'b0, r, q};
      end
      4'd4: begin
        if (b == 0) return {1'b1, 64'd0};
        return {1'b0, a % b, a / b};
      end
      default: return 65'd0;
    endcase
  endfunction

  // Monitor: each time busyE falls, pop the expected result and check HI/LO and busy length.
  initial begin
    int   cnt;
    exp_t e;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (busyE) cnt++;
      else if (cnt > 0) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_commit", 1'b1, 1'b0);
        end else begin
          e = sb.pop_front();
          chk("sb_hi", hiE, e.hi);
          chk("sb_lo", loE, e.lo);
          chk("sb_busy_len", cnt, e.len);
        end
        cnt = 0;
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic        was_busy;
    logic [64:0] rr;
    exp_t        e;
    @(posedge clk); #1;
    mdOpE = op; in1E = a; in2E = b;
    #1;
    was_busy = busyE;
    chk("startE", startE, (op >= 1 && op <= 4));
    if (op == 4'd7)      chk("mfhi_out", mdOutE, m_hi);
    else if (op == 4'd8) chk("mflo_out", mdOutE, m_lo);
    else                 chk("mdout_zero", mdOutE, 32'd0);
    @(posedge clk); #1;
    mdOpE = 4'd0;
    if (!was_busy) begin
      if (op >= 1 && op <= 4) begin
        rr = ref_md(op, a, b);
        if (rr[64]) begin pend_hi = m_hi; pend_lo = m_lo; end
        else begin pend_hi = rr[63:32]; pend_lo = rr[31:0]; end
        e.hi = pend_hi; e.lo = pend_lo; e.len = (op >= 3) ? DC : MC;
        sb.push_back(e);
      end else if (op == 4'd5) begin
        m_hi = a;
        chk("mthi", hiE, m_hi);
      end else if (op == 4'd6) begin
        m_lo = a;
        chk("mtlo", loE, m_lo);
      end
    end else begin
      chk("busy_hi_hold", hiE, m_hi);
      chk("busy_lo_hold", loE, m_lo);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busyE && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("busy_timeout", busyE, 1'b0);
    m_hi = pend_hi;
    m_lo = pend_lo;
    chk("idle_hi", hiE, m_hi);
    chk("idle_lo", loE, m_lo);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    exp_t        e;
    reset_n = 0; mdOpE = 0; in1E = 0; in2E = 0; cancelE = 0;
    #12;
    chk("rst_busy", busyE, 1'b0);
    chk("rst_hi", hiE, 32'd0);
    chk("rst_lo", loE, 32'd0);
    chk("rst_start", startE, 1'b0);
    #1 reset_n = 1;

    issue(4'd1, 32'hFFFFFFFE, 32'd3); wait_idle();
    chk("mult_hi_k", hiE, 32'hFFFFFFFF);
    chk("mult_lo_k", loE, 32'hFFFFFFFA);
    issue(4'd2, 32'hFFFFFFFE, 32'd3); wait_idle();
    chk("multu_hi_k", hiE, 32'h00000002);
    chk("multu_lo_k", loE, 32'hFFFFFFFA);
    issue(4'd3, 32'hFFFFFFF9, 32'd2); wait_idle();
    chk("div_lo_k", loE, 32'hFFFFFFFD);
    chk("div_hi_k", hiE, 32'hFFFFFFFF);
    issue(4'd4, 32'd7, 32'd2); wait_idle();
    chk("divu_lo_k", loE, 32'd3);
    chk("divu_hi_k", hiE, 32'd1);
    issue(4'd3, 32'h80000000, 32'hFFFFFFFF); wait_idle();
    chk("divovf_lo_k", loE, 32'h80000000);
    chk("divovf_hi_k", hiE, 32'd0);

    issue(4'd5, 32'h1234, 0);
    issue(4'd6, 32'h5678, 0);
    issue(4'd3, 32'd99, 32'd0); wait_idle();
    chk("div0_hi_k", hiE, 32'h1234);
    chk("div0_lo_k", loE, 32'h5678);
    issue(4'd7, 0, 0);
    issue(4'd8, 0, 0);
    issue(4'd11, 0, 0);

    // Second mult and an mthi on busy cycles are ignored.
    issue(4'd1, 32'd1000, 32'd3);
    issue(4'd1, 32'd7, 32'd9);
    issue(4'd5, 32'hDEAD, 0);
    wait_idle();
    chk("ignore_lo_k", loE, 32'd3000);

    // Async reset on busy cycle 3 of a div.
    issue(4'd3, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    #2 reset_n = 0;
    #1;
    chk("midrst_busy", busyE, 1'b0);
    chk("midrst_hi", hiE, 32'd0);
    chk("midrst_lo", loE, 32'd0);
    void'(sb.pop_back());
    e.hi = 0; e.lo = 0; e.len = 3;
    sb.push_back(e);
    m_hi = 0; m_lo = 0; pend_hi = 0; pend_lo = 0;
    #1 reset_n = 1;
    repeat (12) @(posedge clk);
    #1;
    chk("midrst_nocommit_hi", hiE, 32'd0);
    chk("midrst_nocommit_lo", loE, 32'd0);

`ifdef MDU_CANCEL_EN
    issue(4'd5, 32'hAAAA, 0);
    issue(4'd1, 32'd5, 32'd6);
    repeat (MC - 2) @(posedge clk);
    #1 cancelE = 1;
    @(posedge clk); #1 cancelE = 0;
    chk("cancel_busy", busyE, 1'b0);
    void'(sb.pop_back());
    e.hi = m_hi; e.lo = m_lo; e.len = MC;
    sb.push_back(e);
    pend_hi = m_hi; pend_lo = m_lo;
    wait_idle();
`endif

    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(1, 12));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      issue(op, a, b);
      if (op >= 1 && op <= 4) wait_idle();
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
